// File: rtl/countdown_ctrl_if.sv
// Signal bundle between the countdown sequencer and its digit counters.
// master drives commands, presets and counter readback; slave is the sequencer.
interface countdown_ctrl_if;
  logic       start;
  logic       pause;
  logic [3:0] preset_m;
  logic [3:0] preset_st;
  logic [3:0] preset_so;
  logic [3:0] q_m;
  logic [3:0] q_st;
  logic [3:0] q_so;
  logic [2:0] ld_n;
  logic [3:0] d_m;
  logic [3:0] d_st;
  logic [3:0] d_so;
  logic [2:0] ctp;
  logic [2:0] ctt;
  logic       tick;
  logic [2:0] state;
  logic       timeout;

  modport master (
    output start, pause,
    output preset_m, preset_st, preset_so,
    output q_m, q_st, q_so,
    input  ld_n, d_m, d_st, d_so,
    input  ctp, ctt, tick, state, timeout
  );

  modport slave (
    input  start, pause,
    input  preset_m, preset_st, preset_so,
    input  q_m, q_st, q_so,
    output ld_n, d_m, d_st, d_so,
    output ctp, ctt, tick, state, timeout
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Three-digit (M:ST:SO) countdown sequencer driving external BCD counters.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload presets on timeout instead of halting.
module countdown_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input  logic CP,
  input  logic CR,
  countdown_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           st;
  logic [DIV_W-1:0] presc;
  logic             tick_q;
  logic             tout_q;

  logic [3:0] sat_m;
  logic [3:0] sat_st;
  logic [3:0] sat_so;
  logic       preset_zero;
  logic       q_zero;

  assign sat_m  = (bus.preset_m  > 4'd9) ? 4'd9 : bus.preset_m;
  assign sat_st = (bus.preset_st > 4'd5) ? 4'd5 : bus.preset_st;
  assign sat_so = (bus.preset_so > 4'd9) ? 4'd9 : bus.preset_so;

  assign preset_zero = (sat_m == 4'd0) && (sat_st == 4'd0)
                    && (sat_so == 4'd0);
  assign q_zero = (bus.q_m == 4'd0) && (bus.q_st == 4'd0)
               && (bus.q_so == 4'd0);

  assign bus.state   = st;
  assign bus.tick    = tick_q;
  assign bus.timeout = tout_q;

  // FSM, prescaler and registered strobes; CR > start > pause > events
  always_ff @(posedge CP) begin
    if (CR) begin
      st     <= IDLE;
      presc  <= '0;
      tick_q <= 1'b0;
      tout_q <= 1'b0;
    end else if (bus.start) begin
      st     <= LOAD;
      presc  <= '0;
      tick_q <= 1'b0;
      tout_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          tick_q <= 1'b0;
          tout_q <= 1'b0;
        end
        LOAD: begin
          presc  <= '0;
          tick_q <= 1'b0;
          if (preset_zero) begin
            st     <= DONE;
            tout_q <= 1'b1;
          end else begin
            st     <= RUN;
            tout_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.pause) begin
            st <= PAUSE;
          end else if (q_zero) begin
            // zero beats tick so no digit ever underflows to 4'hF
            presc  <= '0;
            tick_q <= 1'b0;
            tout_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            st     <= LOAD;
`else
            st     <= DONE;
`endif
          end else if (presc == DIV_LAST) begin
            presc  <= '0;
            tick_q <= 1'b1;
          end else begin
            presc  <= presc + 1'b1;
            tick_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.pause) st <= RUN;
        end
        DONE: begin
          tout_q <= 1'b1;
        end
        default: begin
          st     <= IDLE;
          presc  <= '0;
          tick_q <= 1'b0;
          tout_q <= 1'b0;
        end
      endcase
    end
  end

  // counter controls: preset load, or borrow chain on a tick cycle
  always_comb begin
    bus.ld_n = 3'b111;
    bus.ctp  = 3'b000;
    bus.ctt  = 3'b000;
    bus.d_m  = 4'd0;
    bus.d_st = 4'd0;
    bus.d_so = 4'd0;
    if (!CR) begin
      if (st == LOAD) begin
        bus.ld_n = 3'b000;
        bus.d_m  = sat_m;
        bus.d_st = sat_st;
        bus.d_so = sat_so;
      end else if (st == RUN && tick_q && !q_zero) begin
        bus.ctp = 3'b111;
        if (bus.q_so != 4'd0) begin
          bus.ctt[0] = 1'b1;
        end else begin
          bus.ld_n[0] = 1'b0;
          bus.d_so    = 4'd9;
          if (bus.q_st != 4'd0) begin
            bus.ctt[1] = 1'b1;
          end else begin
            bus.ld_n[1] = 1'b0;
            bus.d_st    = 4'd5;
            bus.ctt[2]  = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with behavioural BCD down-counters.
// Honors COUNTDOWN_AUTO_RELOAD_EN when the design is built with it.
module tb_countdown_ctrl;
  localparam int TD = 4;

  logic CP = 1'b0;
  logic CR;

  countdown_ctrl_if bus();

  countdown_ctrl #(.TICK_DIV(TD), .DIV_W(3)) dut (
    .CP (CP),
    .CR (CR),
    .bus(bus)
  );

  always #5 CP = ~CP;

  logic [3:0] cm  = 4'd0;
  logic [3:0] cst = 4'd0;
  logic [3:0] cso = 4'd0;

  assign bus.q_m  = cm;
  assign bus.q_st = cst;
  assign bus.q_so = cso;

  // external down-counters: sync load dominates, step when CTP&CTT
  always @(posedge CP) begin
    if (!bus.ld_n[0]) cso <= bus.d_so;
    else if (bus.ctp[0] && bus.ctt[0]) cso <= cso - 4'd1;
    if (!bus.ld_n[1]) cst <= bus.d_st;
    else if (bus.ctp[1] && bus.ctt[1]) cst <= cst - 4'd1;
    if (!bus.ld_n[2]) cm <= bus.d_m;
    else if (bus.ctp[2] && bus.ctt[2]) cm <= cm - 4'd1;
  end

  int total = 0;
  int bad   = 0;
  logic [11:0] sbq[$];

  typedef struct {
    logic [3:0] pm, pst, pso;
    logic [3:0] em, est, eso;
    logic [2:0] enext;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] bcd(input int s);
    logic [3:0] m, t, o;
    m = 4'(s / 60);
    t = 4'((s % 60) / 10);
    o = 4'(s % 10);
    return {m, t, o};
  endfunction

  task automatic set_presets(input logic [3:0] m, input logic [3:0] t,
                             input logic [3:0] o);
    bus.preset_m  = m;
    bus.preset_st = t;
    bus.preset_so = o;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge CP);
    bus.start = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (!bus.tick && n < 2 * TD + 2) begin
      @(negedge CP);
      n++;
    end
  endtask

  // full run; scoreboard holds the reading expected at each tick
  task automatic run_countdown(input logic [3:0] m, input logic [3:0] t,
                               input logic [3:0] o);
    int secs;
    int n;
    bit first;
    logic [11:0] exp;
    secs = int'(m) * 60 + int'(t) * 10 + int'(o);
    for (int s = secs; s > 0; s--) sbq.push_back(bcd(s));
    set_presets(m, t, o);
    pulse_start();
    chk("run_load_state", bus.state, 3'd1);
    @(negedge CP);
    first = 1'b1;
    while (sbq.size() > 0) begin
      wait_tick(n);
      if (!bus.tick) begin
        chk("tick_timeout", 32'd0, 32'd1);
        sbq.delete();
        break;
      end
      chk("tick_gap", n, first ? TD : TD - 1);
      first = 1'b0;
      exp = sbq.pop_front();
      chk("step_value", {cm, cst, cso}, exp);
      @(negedge CP);
    end
    chk("zero_reached", {cm, cst, cso}, 12'h000);
    chk("zero_state_run", bus.state, 3'd2);
    chk("zero_no_step", bus.ctp, 3'b000);
    @(negedge CP);
    chk("timeout_hi", bus.timeout, 1'b1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    chk("reload_state", bus.state, 3'd1);
    chk("reload_ldn", bus.ld_n, 3'b000);
    @(negedge CP);
    chk("reload_pulse_end", bus.timeout, 1'b0);
    chk("reload_run", bus.state, 3'd2);
    chk("reload_value", {cm, cst, cso}, {m, t, o});
`else
    chk("done_state", bus.state, 3'd4);
    repeat (2 * TD) @(negedge CP);
    chk("done_hold", bus.state, 3'd4);
    chk("done_timeout", bus.timeout, 1'b1);
    chk("done_value", {cm, cst, cso}, 12'h000);
`endif
  endtask

  initial begin
    logic [11:0] saved;
    bit stable;
    int n;

    vt[0] = '{4'd0,  4'd1,  4'd2,  4'd0, 4'd1, 4'd2, 3'd2};
    vt[1] = '{4'd12, 4'd7,  4'd15, 4'd9, 4'd5, 4'd9, 3'd2};
    vt[2] = '{4'd0,  4'd0,  4'd0,  4'd0, 4'd0, 4'd0, 3'd4};
    vt[3] = '{4'd9,  4'd5,  4'd9,  4'd9, 4'd5, 4'd9, 3'd2};
    vt[4] = '{4'd15, 4'd15, 4'd0,  4'd9, 4'd5, 4'd0, 3'd2};
    vt[5] = '{4'd0,  4'd6,  4'd0,  4'd0, 4'd5, 4'd0, 3'd2};

    CR = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    set_presets(4'd0, 4'd0, 4'd0);
    repeat (2) @(negedge CP);
    chk("rst_state", bus.state, 3'd0);
    chk("rst_tick", bus.tick, 1'b0);
    chk("rst_timeout", bus.timeout, 1'b0);
    chk("rst_ldn", bus.ld_n, 3'b111);
    chk("rst_ct", {bus.ctp, bus.ctt}, 6'd0);
    CR = 1'b0;

    bus.pause = 1'b1;
    @(negedge CP);
    bus.pause = 1'b0;
    chk("idle_ignores_pause", bus.state, 3'd0);

    for (int i = 0; i < 6; i++) begin
      set_presets(vt[i].pm, vt[i].pst, vt[i].pso);
      pulse_start();
      chk("vec_load_state", bus.state, 3'd1);
      chk("vec_ldn", bus.ld_n, 3'b000);
      chk("vec_d", {bus.d_m, bus.d_st, bus.d_so},
          {vt[i].em, vt[i].est, vt[i].eso});
      @(negedge CP);
      chk("vec_next", bus.state, vt[i].enext);
      chk("vec_q", {cm, cst, cso}, {vt[i].em, vt[i].est, vt[i].eso});
      if (vt[i].enext == 3'd4) begin
        chk("vec_done_to", bus.timeout, 1'b1);
        stable = 1'b1;
        repeat (3 * TD) begin
          @(negedge CP);
          if (bus.tick || bus.ctp != 3'b000) stable = 1'b0;
        end
        chk("vec_no_tick", stable, 1'b1);
      end
    end

    run_countdown(4'd0, 4'd1, 4'd2);
    run_countdown(4'd1, 4'd0, 4'd0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    bus.pause = 1'b1;
    @(negedge CP);
    bus.pause = 1'b0;
    chk("done_ignores_pause", bus.state, 3'd4);
`endif

    set_presets(4'd0, 4'd5, 4'd5);
    pulse_start();
    repeat (6) @(negedge CP);
    saved = {cm, cst, cso};
    CR = 1'b1;
    stable = 1'b1;
    repeat (2) begin
      if (bus.ld_n != 3'b111 || bus.ctp != 3'b000 || bus.ctt != 3'b000)
        stable = 1'b0;
      @(negedge CP);
    end
    chk("cr_ctl_idle", stable, 1'b1);
    chk("cr_state", bus.state, 3'd0);
    chk("cr_timeout", bus.timeout, 1'b0);
    chk("cr_tick", bus.tick, 1'b0);
    chk("cr_q_kept", {cm, cst, cso}, saved);
    CR = 1'b0;

    set_presets(4'd0, 4'd3, 4'd0);
    pulse_start();
    @(negedge CP);
    wait_tick(n);
    chk("p_first_tick", bus.tick, 1'b1);
    repeat (2) @(negedge CP);
    bus.pause = 1'b1;
    @(negedge CP);
    bus.pause = 1'b0;
    chk("p_state", bus.state, 3'd3);
    chk("p_q", {cm, cst, cso}, 12'h029);
    saved = {cm, cst, cso};
    stable = 1'b1;
    repeat (20) begin
      if (bus.ctp != 3'b000 || bus.ctt != 3'b000 || bus.ld_n != 3'b111 ||
          bus.tick || {cm, cst, cso} != saved || bus.state != 3'd3)
        stable = 1'b0;
      @(negedge CP);
    end
    chk("p_hold", stable, 1'b1);
    bus.pause = 1'b1;
    @(negedge CP);
    bus.pause = 1'b0;
    chk("p_resume", bus.state, 3'd2);
    chk("p_r0_tick", bus.tick, 1'b0);
    @(negedge CP);
    chk("p_r1_tick", bus.tick, 1'b0);
    @(negedge CP);
    chk("p_r2_tick", bus.tick, 1'b1);
    chk("p_r2_ctp", bus.ctp, 3'b111);

    set_presets(4'd0, 4'd0, 4'd3);
    bus.start = 1'b1;
    bus.pause = 1'b1;
    @(negedge CP);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    chk("start_beats_pause", bus.state, 3'd1);

    run_countdown(4'd0, 4'd0, 4'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
